// File: rtl/sm_extrema_tracker.sv
// Frame-based max/min tracker for sign-magnitude samples with a valid/ready result hold.
// Define SM_TRACKER_IDX_EN to add o_max_idx/o_min_idx ports and their position tracking.
module sm_extrema_tracker #(
  parameter int N     = 8,
  parameter int FRAME = 16,
  localparam int CW   = $clog2(FRAME + 1),
  localparam int IW   = ($clog2(FRAME) > 1) ? $clog2(FRAME) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [N-1:0]  i_data,
  input  logic          i_last,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [N-1:0]  o_max,
  output logic [N-1:0]  o_min,
  output logic [CW-1:0] o_count
`ifdef SM_TRACKER_IDX_EN
  ,
  output logic [IW-1:0] o_max_idx,
  output logic [IW-1:0] o_min_idx
`endif
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t state, state_next;
  logic   accept;
  logic   frame_full;

  // Signed-magnitude "a > b"; a zero magnitude counts as non-negative so +0 == -0.
  function automatic logic sm_gt(input logic [N-1:0] a, input logic [N-1:0] b);
    logic a_neg, b_neg;
    a_neg = a[N-1] & (a[N-2:0] != '0);
    b_neg = b[N-1] & (b[N-2:0] != '0);
    if (a_neg != b_neg)
      return !a_neg;
    else if (!a_neg)
      return a[N-2:0] > b[N-2:0];
    else
      return a[N-2:0] < b[N-2:0];
  endfunction

  assign o_ready    = (state != HOLD);
  assign o_valid    = (state == HOLD);
  assign accept     = i_valid && o_ready;
  assign frame_full = ((o_count + CW'(1)) == CW'(FRAME));

  always_ff @(posedge i_clk) begin
    if (i_rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = i_last ? HOLD : ACC;
      ACC:  if (accept && (i_last || frame_full)) state_next = HOLD;
      HOLD: if (i_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strict comparisons below make ties keep the earlier sample and its position.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_max   <= '0;
      o_min   <= '0;
      o_count <= '0;
    end else if (accept) begin
      if (state == IDLE) begin
        o_max   <= i_data;
        o_min   <= i_data;
        o_count <= CW'(1);
      end else begin
        o_count <= o_count + CW'(1);
        if (sm_gt(i_data, o_max)) o_max <= i_data;
        if (sm_gt(o_min, i_data)) o_min <= i_data;
      end
    end
  end

`ifdef SM_TRACKER_IDX_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_max_idx <= '0;
      o_min_idx <= '0;
    end else if (accept) begin
      if (state == IDLE) begin
        o_max_idx <= '0;
        o_min_idx <= '0;
      end else begin
        if (sm_gt(i_data, o_max)) o_max_idx <= IW'(o_count);
        if (sm_gt(o_min, i_data)) o_min_idx <= IW'(o_count);
      end
    end
  end
`endif

endmodule

// File: tb/tb_sm_extrema_tracker.sv
// Directed self-checking bench for sm_extrema_tracker (N=8, FRAME=4).
// Index checks are active when SM_TRACKER_IDX_EN is defined.
module tb_sm_extrema_tracker;

  localparam int N     = 8;
  localparam int FRAME = 4;
  localparam int CW    = $clog2(FRAME + 1);
  localparam int IW    = 2;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [N-1:0]  i_data = '0;
  logic          i_last = 1'b0;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [N-1:0]  o_max;
  logic [N-1:0]  o_min;
  logic [CW-1:0] o_count;
`ifdef SM_TRACKER_IDX_EN
  logic [IW-1:0] o_max_idx;
  logic [IW-1:0] o_min_idx;
`endif

  int checks = 0;
  int errors = 0;

  sm_extrema_tracker #(.N(N), .FRAME(FRAME)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .i_last  (i_last),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_max   (o_max),
    .o_min   (o_min),
    .o_count (o_count)
`ifdef SM_TRACKER_IDX_EN
    ,
    .o_max_idx (o_max_idx),
    .o_min_idx (o_min_idx)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Present one sample and hold it until the DUT accepts it (bounded).
  task automatic applyStimulus(input logic [N-1:0] d, input logic last);
    bit done = 0;
    i_valid = 1'b1;
    i_data  = d;
    i_last  = last;
    for (int t = 0; t < 20 && !done; t++) begin
      if (o_ready) done = 1;
      tick();
    end
    checkOutput("accept_timeout", {31'd0, done}, 32'd1);
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic waitResult(input string tag);
    for (int t = 0; t < 10 && !o_valid; t++) tick();
    checkOutput(tag, {31'd0, o_valid}, 32'd1);
  endtask

  task automatic checkResult(input string tag, input logic [N-1:0] mx, input logic [N-1:0] mn,
                             input int cnt, input int mxi, input int mni);
    checkOutput({tag, "_max"}, 32'(o_max), 32'(mx));
    checkOutput({tag, "_min"}, 32'(o_min), 32'(mn));
    checkOutput({tag, "_count"}, 32'(o_count), 32'(cnt));
`ifdef SM_TRACKER_IDX_EN
    checkOutput({tag, "_max_idx"}, 32'(o_max_idx), 32'(mxi));
    checkOutput({tag, "_min_idx"}, 32'(o_min_idx), 32'(mni));
`else
    if (mxi < 0 || mni < 0) $display("[TB] note: negative index argument");
`endif
  endtask

  task automatic takeResult(input string tag);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, {31'd0, o_valid}, 32'd0);
    checkOutput({tag, "_ready_back"}, {31'd0, o_ready}, 32'd1);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    checkOutput("rst_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("rst_ready", {31'd0, o_ready}, 32'd1);
    checkResult("rst", 8'h00, 8'h00, 0, 0, 0);
    i_rst = 1'b0;
    tick();

    // Full frame with mixed signs, plus latency of o_valid
    applyStimulus(8'h03, 1'b0);
    applyStimulus(8'h85, 1'b0);
    applyStimulus(8'h7F, 1'b0);
    checkOutput("mix_not_yet_valid", {31'd0, o_valid}, 32'd0);
    applyStimulus(8'h80, 1'b0);
    checkOutput("mix_latency", {31'd0, o_valid}, 32'd1);
    checkOutput("mix_hold_ready", {31'd0, o_ready}, 32'd0);
    checkResult("mix", 8'h7F, 8'h85, 4, 2, 1);
    takeResult("mix");

    // -0 followed by +0 ends early; the tie keeps the first, bit-exact
    applyStimulus(8'h80, 1'b0);
    applyStimulus(8'h00, 1'b1);
    waitResult("zero_valid");
    checkResult("zero", 8'h80, 8'h80, 2, 0, 0);
    takeResult("zero");

    // All negative
    applyStimulus(8'h81, 1'b0);
    applyStimulus(8'h82, 1'b0);
    applyStimulus(8'h83, 1'b0);
    applyStimulus(8'h84, 1'b0);
    waitResult("neg_valid");
    checkResult("neg", 8'h81, 8'h84, 4, 0, 3);
    takeResult("neg");

    // Single-sample frame, result held under backpressure, i_valid ignored in HOLD
    applyStimulus(8'h05, 1'b1);
    waitResult("single_valid");
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        i_valid = 1'b1;
        i_data  = 8'h7F;
        i_last  = 1'b1;
      end
      tick();
      i_valid = 1'b0;
      i_last  = 1'b0;
      checkOutput("hold_ready", {31'd0, o_ready}, 32'd0);
      checkOutput("hold_valid", {31'd0, o_valid}, 32'd1);
      checkResult("hold", 8'h05, 8'h05, 1, 0, 0);
    end
    takeResult("single");

    // Reset mid-frame discards the partial frame
    applyStimulus(8'h10, 1'b0);
    applyStimulus(8'h20, 1'b0);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    checkOutput("midrst_valid", {31'd0, o_valid}, 32'd0);
    checkResult("midrst", 8'h00, 8'h00, 0, 0, 0);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h02, 1'b0);
    applyStimulus(8'h03, 1'b0);
    applyStimulus(8'h04, 1'b0);
    waitResult("postrst_valid");
    checkResult("postrst", 8'h04, 8'h01, 4, 3, 0);

    // Reset wins over a simultaneous result handshake
    i_rst   = 1'b1;
    i_ready = 1'b1;
    tick();
    i_rst   = 1'b0;
    i_ready = 1'b0;
    checkOutput("rstprio_valid", {31'd0, o_valid}, 32'd0);
    checkResult("rstprio", 8'h00, 8'h00, 0, 0, 0);

    // Gappy i_valid with a stray i_last during idle gaps
    for (int k = 0; k < 4; k++) begin
      int gap;
      logic [N-1:0] v;
      case (k)
        0: v = 8'h7F;
        1: v = 8'hFF;
        2: v = 8'h00;
        default: v = 8'h01;
      endcase
      gap = int'($urandom_range(0, 3));
      i_last = 1'b1;
      for (int g = 0; g < gap; g++) tick();
      i_last = 1'b0;
      applyStimulus(v, 1'b0);
    end
    waitResult("gappy_valid");
    checkResult("gappy", 8'h7F, 8'hFF, 4, 0, 1);
    takeResult("gappy");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm_extrema_tracker.md
SM_EXTREMA_TRACKER -- requirements
Module: sm_extrema_tracker

Interface
REQ-001 SHALL have parameter N, default 8: sample width; bit N-1 is the sign (1 = minus), bits N-2:0 are the magnitude; N >= 2.
REQ-002 SHALL have parameter FRAME, default 16: maximum samples per frame; FRAME >= 2.
REQ-003 SHALL have port i_clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port i_valid, input, 1: input sample valid.
REQ-006 SHALL have port o_ready, output, 1: block accepts a sample this cycle.
REQ-007 SHALL have port i_data, input, N: sign-magnitude sample.
REQ-008 SHALL have port i_last, input, 1: the accepted sample ends the frame early.
REQ-009 SHALL have port o_valid, output, 1: frame result valid.
REQ-010 SHALL have port i_ready, input, 1: downstream accepts the result.
REQ-011 SHALL have port o_max, output, N: largest sample of the frame.
REQ-012 SHALL have port o_min, output, N: smallest sample of the frame.
REQ-013 SHALL have port o_count, output, $clog2(FRAME+1): number of samples in the frame.
REQ-014 SHALL have port o_max_idx, output, max(1,$clog2(FRAME)): position of o_max (present only with the macro in REQ-032).
REQ-015 SHALL have port o_min_idx, output, max(1,$clog2(FRAME)): position of o_min (present only with the macro in REQ-032).

Function
REQ-016 SHALL order samples as sign-magnitude signed values: any plus value > any minus value; among plus values the larger magnitude is greater; among minus values the smaller magnitude is greater.
REQ-017 SHALL treat +0 (all bits 0) and -0 (only the sign bit set) as equal.
REQ-018 SHALL implement the states IDLE, ACC and HOLD.
REQ-019 SHALL drive o_ready = 1 in IDLE and ACC and o_ready = 0 in HOLD; a sample is accepted when i_valid && o_ready.
REQ-020 SHALL, on a sample accepted in IDLE, load o_max = o_min = i_data, set the count to 1 and both indices to 0, then go to ACC.
REQ-021 SHALL, on a sample accepted in ACC, replace the maximum only if the sample is strictly greater and the minimum only if it is strictly smaller, so ties keep the earlier sample and its index.
REQ-022 SHALL end the frame on the accepted sample that has i_last = 1 or that brings the count to FRAME, whichever occurs first; a 1-sample frame (i_last in IDLE) is legal.
REQ-023 SHALL enter HOLD with o_valid = 1 in the cycle after the frame-ending sample is accepted (latency 1 cycle).
REQ-024 SHALL keep o_max, o_min, o_count and the indices stable in HOLD until o_valid && i_ready.
REQ-025 SHALL go to IDLE on the result handshake, with o_valid = 0 the next cycle; a new frame may start in the following cycle.
REQ-026 SHALL ignore i_last when no sample is accepted.
REQ-027 SHALL ignore i_data and i_valid while in HOLD.
REQ-028 SHALL store o_max and o_min bit-exact as received, so -0 is not normalised to +0.

Reset
REQ-029 SHALL, while i_rst = 1 at a clock edge, go to IDLE and clear o_valid, o_max, o_min, o_count and the indices to 0; o_ready becomes 1.
REQ-030 SHALL, when reset is asserted mid-frame or in HOLD, discard the partial or pending result.
REQ-031 SHALL give reset priority over a sample handshake and a result handshake in the same cycle.

Configuration
REQ-032 SHALL include the o_max_idx and o_min_idx ports and their tracking logic only when SM_TRACKER_IDX_EN is defined; when the macro is undefined the ports and logic are absent and all other behaviour is unchanged.

Verification (N=8, FRAME=4, SM_TRACKER_IDX_EN defined)
REQ-033 SHALL check: feed 03,85,7F,80 -> o_max=7F, o_min=85, o_count=4, o_max_idx=2, o_min_idx=1, with o_valid rising 1 cycle after the 4th sample.
REQ-034 SHALL check: feed 80,00 with i_last on 00 -> o_max=80, o_min=80, o_count=2, both indices 0 (-0 ties +0).
REQ-035 SHALL check: feed 81,82,83,84 -> o_max=81 (idx 0), o_min=84 (idx 3).
REQ-036 SHALL check: single sample 05 with i_last, then hold i_ready=0 for 5 cycles -> o_ready=0 and outputs stable; an i_valid pulse during HOLD is ignored; i_ready=1 -> IDLE, o_valid=0.
REQ-037 SHALL check: feed 10,20, then assert i_rst, then feed 01,02,03,04 -> the result is o_max=04, o_min=01, o_count=4, with no trace of 10 or 20.
REQ-038 SHALL check: toggle i_valid randomly over the frame 7F,FF,00,01 -> same result as back-to-back: o_max=7F, o_min=FF.
